// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART receiver.
package uart_pkg;

   // Receiver FSM states.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_DATA     = 3'd2,
      ST_PARITY   = 3'd3,
      ST_STOP     = 3'd4,
      ST_BRK_WAIT = 3'd5
   } rx_state_e;

   // PARITY_MODE encodings.
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Even-parity reduction: 1 when the vector holds an odd number of ones.
   // Narrower words are zero-extended by the caller.
   function automatic logic even_parity(input logic [15:0] vec);
      return ^vec;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: brings the asynchronous rx line into the clock domain and
// forms a 3-sample majority vote. The window is the two samples stored on the
// previous two ticks plus the sample being taken on the current tick, so the
// vote evaluated on tick H+1 covers ticks H-1, H and H+1.
module uart_rx_sampler (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   input  logic sample_tick,
   output logic rx_sync,
   output logic rx_vote
);

   logic       sync1_q;
   logic       sync2_q;
   logic [1:0] hist_q;

   // Two-flop synchronizer; flops idle high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
      end
   end

   // Sample history, advanced only on sample ticks (hist_q[0] is the newest).
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= 2'b11;
      end else if (sample_tick) begin
         hist_q <= {hist_q[0], sync2_q};
      end
   end

   assign rx_sync = sync2_q;
   assign rx_vote = (hist_q[1] & hist_q[0]) |
                    (hist_q[1] & sync2_q)   |
                    (hist_q[0] & sync2_q);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver. Holds the frame FSM, tick/bit
// counters, data shift register and the registered result flags.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DBITS       = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int PARITY_MODE = PAR_NONE,
   parameter int STOP_BITS   = 1
) (
   input  logic             clk_100MHz,
   input  logic             reset,
   input  logic             rx,
   input  logic             sample_tick,
   output logic [DBITS-1:0] data_out,
   output logic             data_ready,
   output logic             parity_err,
   output logic             frame_err,
   output logic             break_det,
   output logic             busy
);

   localparam int TCW = ($clog2(OVERSAMPLE) < 1) ? 1 : $clog2(OVERSAMPLE);
   localparam int BCW = ($clog2(DBITS) < 1) ? 1 : $clog2(DBITS);

   // Mid-sample tick is H+1 = OVERSAMPLE/2; majority window ends there.
   localparam logic [TCW-1:0] TICK_MID  = TCW'(OVERSAMPLE / 2);
   localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(DBITS - 1);
   localparam logic           STOP_LAST = (STOP_BITS == 2);
   localparam logic           HAS_PAR   = (PARITY_MODE != PAR_NONE);

   rx_state_e        state_q;
   logic [TCW-1:0]   tick_q;
   logic [TCW-1:0]   tick_d;
   logic [BCW-1:0]   bit_q;
   logic             stop_q;
   logic [DBITS-1:0] shreg_q;
   logic [DBITS-1:0] shreg_d;
   logic             par_q;
   logic             stop_zero_q;
   logic             stop_one_q;
   logic             par_xor;
   logic             perr_d;
   logic             ferr_d;
   logic             brk_d;

   logic [DBITS-1:0] data_out_q;
   logic             ready_q;
   logic             perr_q;
   logic             ferr_q;
   logic             brk_q;
   logic             busy_q;

   logic             rx_sync;
   logic             rx_vote;

   uart_rx_sampler u_sampler (
      .clk         (clk_100MHz),
      .reset       (reset),
      .rx          (rx),
      .sample_tick (sample_tick),
      .rx_sync     (rx_sync),
      .rx_vote     (rx_vote)
   );

   // Next-value helpers: counter increment, shifted word and completion flags
   // (the current vote is the last stop sample when the frame completes).
   always_comb begin
      tick_d  = tick_q + TCW'(1);
      shreg_d = {rx_vote, shreg_q[DBITS-1:1]};
      par_xor = even_parity(16'(shreg_q)) ^ par_q;
      case (PARITY_MODE)
         PAR_EVEN: perr_d = par_xor;
         PAR_ODD:  perr_d = ~par_xor;
         default:  perr_d = 1'b0;
      endcase
      brk_d  = (shreg_q == '0) && (!HAS_PAR || !par_q) && !stop_one_q && !rx_vote;
      ferr_d = stop_zero_q | ~rx_vote;
   end

   // Frame FSM with counters, shift register and registered result outputs.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tick_q      <= '0;
         bit_q       <= '0;
         stop_q      <= 1'b0;
         shreg_q     <= '0;
         par_q       <= 1'b0;
         stop_zero_q <= 1'b0;
         stop_one_q  <= 1'b0;
         data_out_q  <= '0;
         ready_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         brk_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         brk_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // A tick in the detection cycle is deliberately not counted.
               if (!rx_sync) begin
                  state_q     <= ST_START;
                  busy_q      <= 1'b1;
                  tick_q      <= '0;
                  bit_q       <= '0;
                  stop_q      <= 1'b0;
                  stop_zero_q <= 1'b0;
                  stop_one_q  <= 1'b0;
               end
            end
            ST_START: begin
               if (sample_tick) begin
                  if ((tick_q == TICK_MID) && rx_vote) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else if (tick_q == TICK_LAST) begin
                     tick_q  <= '0;
                     bit_q   <= '0;
                     state_q <= ST_DATA;
                  end else begin
                     tick_q <= tick_d;
                  end
               end
            end
            ST_DATA: begin
               if (sample_tick) begin
                  if (tick_q == TICK_MID) begin
                     shreg_q <= shreg_d;
                  end
                  if (tick_q == TICK_LAST) begin
                     tick_q <= '0;
                     if (bit_q == BIT_LAST) begin
                        if (HAS_PAR) begin
                           state_q <= ST_PARITY;
                        end else begin
                           state_q <= ST_STOP;
                        end
                     end else begin
                        bit_q <= bit_q + BCW'(1);
                     end
                  end else begin
                     tick_q <= tick_d;
                  end
               end
            end
            ST_PARITY: begin
               if (sample_tick) begin
                  if (tick_q == TICK_MID) begin
                     par_q <= rx_vote;
                  end
                  if (tick_q == TICK_LAST) begin
                     tick_q  <= '0;
                     stop_q  <= 1'b0;
                     state_q <= ST_STOP;
                  end else begin
                     tick_q <= tick_d;
                  end
               end
            end
            ST_STOP: begin
               if (sample_tick) begin
                  if ((tick_q == TICK_MID) && (stop_q == STOP_LAST)) begin
                     // Complete at the last stop mid-sample so a back-to-back
                     // start bit is not missed.
                     data_out_q <= shreg_q;
                     perr_q     <= perr_d;
                     ferr_q     <= ferr_d;
                     ready_q    <= 1'b1;
                     brk_q      <= brk_d;
                     if (brk_d) begin
                        state_q <= ST_BRK_WAIT;
                     end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     if (tick_q == TICK_MID) begin
                        stop_zero_q <= stop_zero_q | ~rx_vote;
                        stop_one_q  <= stop_one_q | rx_vote;
                     end
                     if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        stop_q <= 1'b1;
                     end else begin
                        tick_q <= tick_d;
                     end
                  end
               end
            end
            ST_BRK_WAIT: begin
               // Hold off new frames until the line has returned to idle.
               if (rx_sync) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out   = data_out_q;
   assign data_ready = ready_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign break_det  = brk_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: three receiver configurations (8N1, 8E2, 9O1) driven by
// randomized and directed frames; expected results from a frame-level model
// are queued at stimulus time and popped by a monitor on data_ready.
module tb_uart_rx_param;

   localparam int OS       = 16;
   localparam int TICK_DIV = 4;
   localparam int NB [3] = '{8, 8, 9};
   localparam int PM [3] = '{0, 1, 2};
   localparam int NS [3] = '{1, 2, 1};

   typedef struct {
      int         inst;
      logic [8:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
   } exp_t;

   exp_t exp_q [$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       rx_l [3];
   logic [7:0] dout0;
   logic [7:0] dout1;
   logic [8:0] dout2;
   logic [8:0] dout_a [3];
   logic       dr_a [3];
   logic       pe_a [3];
   logic       fe_a [3];
   logic       brk_a [3];
   logic       busy_a [3];
   event       tick_ev;

   assign dout_a[0] = {1'b0, dout0};
   assign dout_a[1] = {1'b0, dout1};
   assign dout_a[2] = dout2;

   uart_rx_param #(.DBITS(8), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
      .clk_100MHz(clk), .reset(rst), .rx(rx_l[0]), .sample_tick(tick),
      .data_out(dout0), .data_ready(dr_a[0]), .parity_err(pe_a[0]),
      .frame_err(fe_a[0]), .break_det(brk_a[0]), .busy(busy_a[0]));

   uart_rx_param #(.DBITS(8), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(2)) dut1 (
      .clk_100MHz(clk), .reset(rst), .rx(rx_l[1]), .sample_tick(tick),
      .data_out(dout1), .data_ready(dr_a[1]), .parity_err(pe_a[1]),
      .frame_err(fe_a[1]), .break_det(brk_a[1]), .busy(busy_a[1]));

   uart_rx_param #(.DBITS(9), .OVERSAMPLE(OS), .PARITY_MODE(2), .STOP_BITS(1)) dut2 (
      .clk_100MHz(clk), .reset(rst), .rx(rx_l[2]), .sample_tick(tick),
      .data_out(dout2), .data_ready(dr_a[2]), .parity_err(pe_a[2]),
      .frame_err(fe_a[2]), .break_det(brk_a[2]), .busy(busy_a[2]));

   // Clock.
   initial forever #5 clk = ~clk;

   // sample_tick: one clock high every TICK_DIV clocks; tick_ev marks the end of each tick.
   initial begin
      forever begin
         repeat (TICK_DIV - 1) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         ->tick_ev;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) @(tick_ev);
   endtask

   // One bit period; gpos != 0 inverts the line for the gpos-th tick only.
   task automatic drive_bit(input int inst, input logic val, input int gpos);
      rx_l[inst] = val;
      if (gpos == 0) begin
         wait_ticks(OS);
      end else begin
         wait_ticks(gpos - 1);
         rx_l[inst] = ~val;
         wait_ticks(1);
         rx_l[inst] = val;
         wait_ticks(OS - gpos);
      end
   endtask

   // Reference model: result of one frame from the bits placed on the line.
   function automatic exp_t make_exp(input int inst, input logic [8:0] d, input logic p,
                                     input logic [1:0] stops);
      exp_t e;
      int   ones;
      logic any_zero;
      logic all_zero;
      ones     = $countones(d);
      any_zero = !stops[0] || (NS[inst] == 2 && !stops[1]);
      all_zero = !stops[0] && (NS[inst] == 1 || !stops[1]);
      e.inst   = inst;
      e.data   = d;
      if (PM[inst] == 0) e.perr = 1'b0;
      else e.perr = (((ones + int'(p)) % 2) != ((PM[inst] == 2) ? 1 : 0));
      e.brk  = (d == 9'd0) && (PM[inst] == 0 || !p) && all_zero;
      e.ferr = any_zero;
      return e;
   endfunction

   function automatic logic good_par(input int inst, input logic [8:0] d);
      logic odd_ones;
      odd_ones = ($countones(d) % 2) == 1;
      return (PM[inst] == 2) ? ~odd_ones : odd_ones;
   endfunction

   // Push the model result, then put the frame on the line followed by gap idle bits.
   task automatic send_frame(input int inst, input logic [8:0] d, input logic p,
                             input logic [1:0] stops, input int gbit, input int gpos,
                             input int gap);
      exp_q.push_back(make_exp(inst, d, p, stops));
      drive_bit(inst, 1'b0, 0);
      for (int b = 0; b < NB[inst]; b++) drive_bit(inst, d[b], (b == gbit) ? gpos : 0);
      if (PM[inst] != 0) drive_bit(inst, p, 0);
      for (int s = 0; s < NS[inst]; s++) drive_bit(inst, stops[s], 0);
      rx_l[inst] = 1'b1;
      wait_ticks(gap * OS);
   endtask

   // Scoreboard monitor: compare every data_ready against the queued expectation.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (dr_a[i]) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_ready inst%0d: got data %0h expected no frame", i, dout_a[i]);
            end else begin
               mon_e = exp_q.pop_front();
               check("ready_inst", 32'(i), 32'(mon_e.inst));
               check("data_out",   32'(dout_a[i]), 32'(mon_e.data));
               check("parity_err", 32'(pe_a[i]), 32'(mon_e.perr));
               check("frame_err",  32'(fe_a[i]), 32'(mon_e.ferr));
               check("break_det",  32'(brk_a[i]), 32'(mon_e.brk));
            end
         end else if (brk_a[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL break_alone inst%0d: got break_det 1 expected 0 without data_ready", i);
         end
      end
   end

   // Watchdog.
   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation still running, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "timeout");
   end

   // Directed and random stimulus.
   initial begin
      logic [8:0] d;
      logic       p;
      logic [1:0] st;
      int         gap;
      int         gpos;
      rx_l[0] = 1'b1;
      rx_l[1] = 1'b1;
      rx_l[2] = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("rst_data_out", 32'(dout_a[i]), 32'd0);
         check("rst_ready",    32'(dr_a[i]), 32'd0);
         check("rst_flags",    32'({pe_a[i], fe_a[i], brk_a[i]}), 32'd0);
         check("rst_busy",     32'(busy_a[i]), 32'd0);
      end
      rst = 1'b0;
      wait_ticks(2 * OS);

      // 8N1: single word, then two back-to-back words.
      send_frame(0, 9'h0A5, 1'b0, 2'b11, -1, 0, 1);
      send_frame(0, 9'h000, 1'b0, 2'b11, -1, 0, 0);
      send_frame(0, 9'h0FF, 1'b0, 2'b11, -1, 0, 1);

      // False start: low for 3 ticks only.
      rx_l[0] = 1'b0;
      wait_ticks(3);
      check("false_start_busy_hi", 32'(busy_a[0]), 32'd1);
      rx_l[0] = 1'b1;
      wait_ticks(6);
      check("false_start_busy_lo", 32'(busy_a[0]), 32'd0);
      wait_ticks(OS);

      // Single-tick glitch on the mid-sample of data bit 3.
      send_frame(0, 9'h055, 1'b0, 2'b11, 3, 9, 1);
      // Stop bit forced low.
      send_frame(0, 9'h081, 1'b0, 2'b10, -1, 0, 2);

      // Reset in the middle of data bit 4.
      rx_l[0] = 1'b0;
      wait_ticks(5 * OS);
      rx_l[0] = 1'b1;
      wait_ticks(8);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_data_out", 32'(dout_a[0]), 32'd0);
      check("midrst_ready",    32'(dr_a[0]), 32'd0);
      check("midrst_perr",     32'(pe_a[0]), 32'd0);
      check("midrst_ferr",     32'(fe_a[0]), 32'd0);
      check("midrst_break",    32'(brk_a[0]), 32'd0);
      check("midrst_busy",     32'(busy_a[0]), 32'd0);
      rst = 1'b0;
      wait_ticks(2 * OS);

      // Break: line low for two frame times.
      exp_q.push_back(make_exp(0, 9'h000, 1'b0, 2'b00));
      rx_l[0] = 1'b0;
      wait_ticks(20 * OS);
      check("break_wait_busy", 32'(busy_a[0]), 32'd1);
      rx_l[0] = 1'b1;
      wait_ticks(2 * OS);
      check("break_exit_busy", 32'(busy_a[0]), 32'd0);
      send_frame(0, 9'h012, 1'b0, 2'b11, -1, 0, 1);

      // 8E2: correct then wrong parity bit.
      send_frame(1, 9'h03C, 1'b0, 2'b11, -1, 0, 1);
      send_frame(1, 9'h03C, 1'b1, 2'b11, -1, 0, 1);
      // 9O1.
      send_frame(2, 9'h1AB, 1'b1, 2'b11, -1, 0, 1);

      // Random frames on every configuration.
      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 8; n++) begin
            d    = 9'($urandom_range(0, (1 << NB[i]) - 1));
            p    = good_par(i, d) ^ ($urandom_range(0, 3) == 0);
            st   = {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)};
            if ($urandom_range(0, 7) == 0) begin
               d  = 9'd0;
               p  = 1'b0;
               st = 2'b00;
            end
            gap  = $urandom_range(0, 2);
            if (!st[NS[i] - 1] && gap == 0) gap = 1;
            gpos = $urandom_range(0, 3);
            if (gpos != 0) gpos = gpos + 6;
            send_frame(i, d, p, st, $urandom_range(0, NB[i] - 1), gpos, gap);
         end
         wait_ticks(2 * OS);
      end

      wait_ticks(3 * OS);
      check("frames_pending", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
